// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and helpers for the ID-stage hazard/forwarding unit.
package hazard_scoreboard_unit_pkg;

   localparam int unsigned DEF_REGW = 5;
   localparam int unsigned DEF_NSRC = 3;
   localparam int unsigned FWD_RF   = 0;
   localparam int unsigned REG_ZERO = 0;

   // Width of a per-source forward select: RF plus one code per producer stage.
   function automatic int unsigned sel_width(input int unsigned nstg);
      return $clog2(nstg + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage operand/producer bundle and hazard-control outputs.
import hazard_scoreboard_unit_pkg::*;

interface hazard_scoreboard_unit_if #(
   parameter int unsigned NSRC = DEF_NSRC,
   parameter int unsigned NSTG = 3,
   parameter int unsigned REGW = DEF_REGW,
   parameter int unsigned CNTW = 4,
   parameter int unsigned PCW  = 16
);
   localparam int unsigned SELW = sel_width(NSTG);

   logic                   id_valid;
   logic [NSRC*REGW-1:0]   id_src_reg;
   logic [NSRC-1:0]        id_src_use;
   logic                   id_use_cc;
   logic [REGW-1:0]        id_rd;
   logic                   id_we;
   logic                   id_long;
   logic [CNTW-1:0]        id_long_lat;
   logic [NSTG*REGW-1:0]   stg_rd;
   logic [NSTG-1:0]        stg_we;
   logic [NSTG-1:0]        stg_rdy;
   logic                   ex_cc_we;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall_f;
   logic                   stall_d;
   logic                   flush_e;
   logic                   long_busy;
   logic [PCW-1:0]         stall_cycles;

   modport master (
      output id_valid, id_src_reg, id_src_use, id_use_cc, id_rd, id_we, id_long,
             id_long_lat, stg_rd, stg_we, stg_rdy, ex_cc_we,
      input  fwd_sel, stall_f, stall_d, flush_e, long_busy, stall_cycles
   );

   modport slave (
      input  id_valid, id_src_reg, id_src_use, id_use_cc, id_rd, id_we, id_long,
             id_long_lat, stg_rd, stg_we, stg_rdy, ex_cc_we,
      output fwd_sel, stall_f, stall_d, flush_e, long_busy, stall_cycles
   );

endinterface

// File: rtl/hazard_scoreboard_unit_sb_counter.sv
// One scoreboard entry: loadable countdown, busy while nonzero.
module sb_counter #(
   parameter int unsigned CNTW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [CNTW-1:0] load_val,
   output logic            busy_c
);

   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CNTW'(1);
   end

   assign busy_c = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage forwarding select, hazard stall generation, long-op scoreboard
// and saturating stall-cycle counter.
import hazard_scoreboard_unit_pkg::*;

module hazard_scoreboard_unit #(
   parameter int unsigned NSRC = DEF_NSRC,
   parameter int unsigned NSTG = 3,
   parameter int unsigned REGW = DEF_REGW,
   parameter int unsigned CNTW = 4,
   parameter int unsigned PCW  = 16
) (
   input logic                     clk,
   input logic                     rst,
   hazard_scoreboard_unit_if.slave bus
);

   localparam int unsigned SELW = sel_width(NSTG);
   localparam int unsigned NREG = 2 ** REGW;

   logic [NREG-1:0]      busy;
   logic [NSRC*SELW-1:0] fwd_sel_c;
   logic                 stall_c;
   logic                 long_busy_c;
   logic                 issue_c;
   logic                 not_rdy;
   logic                 sb_hz;
   logic                 waw_hz;
   logic                 cc_hz;
   logic                 struct_hz;
   logic [REGW-1:0]      src;
   logic [SELW-1:0]      sel;
   logic                 rdy;
   logic [CNTW-1:0]      load_val;
   logic [PCW-1:0]       stall_cnt;

   // A zero latency would never mark the register, so clamp to one cycle.
   assign load_val = (bus.id_long_lat == '0) ? CNTW'(1) : bus.id_long_lat;

   assign busy[0] = 1'b0;
   for (genvar r = 1; r < NREG; r++) begin : g_sb
      sb_counter #(.CNTW(CNTW)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .load     (issue_c && (bus.id_rd == REGW'(r))),
         .load_val (load_val),
         .busy_c   (busy[r])
      );
   end

   // Forward selection and hazard detection; reset forces every output low.
   always_comb begin
      fwd_sel_c = '0;
      not_rdy   = 1'b0;
      sb_hz     = 1'b0;
      src       = '0;
      sel       = SELW'(FWD_RF);
      rdy       = 1'b1;
      for (int i = 0; i < NSRC; i++) begin
         src = bus.id_src_reg[i*REGW +: REGW];
         sel = SELW'(FWD_RF);
         rdy = 1'b1;
         // Scan oldest to youngest so the youngest match overwrites.
         for (int k = NSTG - 1; k >= 0; k--) begin
            if (bus.id_src_use[i] && (src != REGW'(REG_ZERO)) && bus.stg_we[k] &&
                (bus.stg_rd[k*REGW +: REGW] == src)) begin
               sel = SELW'(k + 1);
               rdy = bus.stg_rdy[k];
            end
         end
         fwd_sel_c[i*SELW +: SELW] = sel;
         if (!rdy)
            not_rdy = 1'b1;
         if (bus.id_src_use[i] && busy[src])
            sb_hz = 1'b1;
      end
      waw_hz      = bus.id_we && busy[bus.id_rd];
      cc_hz       = bus.id_use_cc && bus.ex_cc_we;
      long_busy_c = |busy;
      struct_hz   = bus.id_long && long_busy_c;
      stall_c     = bus.id_valid && (not_rdy || cc_hz || sb_hz || waw_hz || struct_hz);
      issue_c     = bus.id_valid && !stall_c && bus.id_long && bus.id_we &&
                    (bus.id_rd != REGW'(REG_ZERO)) && !rst;
      if (rst) begin
         fwd_sel_c   = '0;
         stall_c     = 1'b0;
         long_busy_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_c && (stall_cnt != '1))
         stall_cnt <= stall_cnt + PCW'(1);
   end

   assign bus.fwd_sel      = fwd_sel_c;
   assign bus.stall_f      = stall_c;
   assign bus.stall_d      = stall_c;
   assign bus.flush_e      = stall_c;
   assign bus.long_busy    = long_busy_c;
   assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: expectations queued at issue,
// compared by an independent negedge monitor.
module tb_hazard_scoreboard_unit;

   localparam int unsigned NSRC = 3;
   localparam int unsigned NSTG = 3;
   localparam int unsigned REGW = 5;
   localparam int unsigned CNTW = 4;
   localparam int unsigned PCW  = 6;
   localparam int unsigned FW   = 6;

   typedef struct {
      string            nm;
      logic [FW-1:0]    fwd;
      logic             stall;
      logic             lb;
      logic             chk_sc;
      logic [PCW-1:0]   sc;
   } exp_t;

   logic   clk;
   logic   rst;
   logic   chk_en;
   exp_t   exp_q[$];
   exp_t   e;
   int     applied;
   int     miscompares;

   hazard_scoreboard_unit_if #(
      .NSRC(NSRC), .NSTG(NSTG), .REGW(REGW), .CNTW(CNTW), .PCW(PCW)
   ) bus ();

   hazard_scoreboard_unit #(
      .NSRC(NSRC), .NSTG(NSTG), .REGW(REGW), .CNTW(CNTW), .PCW(PCW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_en) begin
         applied++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL no_expectation: DUT output at %0t has no queued vector", $time);
         end else begin
            e = exp_q.pop_front();
            if (bus.fwd_sel !== e.fwd || bus.stall_f !== e.stall || bus.stall_d !== e.stall ||
                bus.flush_e !== e.stall || bus.long_busy !== e.lb ||
                (e.chk_sc && bus.stall_cycles !== e.sc)) begin
               miscompares++;
               $display("FAIL %s: got fwd_sel=%h stall_f/d/flush_e=%b%b%b long_busy=%b stall_cycles=%0d; want fwd_sel=%h stall=%b long_busy=%b stall_cycles=%0d (checked=%b)",
                        e.nm, bus.fwd_sel, bus.stall_f, bus.stall_d, bus.flush_e, bus.long_busy,
                        bus.stall_cycles, e.fwd, e.stall, e.lb, e.sc, e.chk_sc);
            end
         end
      end
   end

   task automatic clr();
      bus.id_valid    = 1'b0;
      bus.id_src_reg  = '0;
      bus.id_src_use  = '0;
      bus.id_use_cc   = 1'b0;
      bus.id_rd       = '0;
      bus.id_we       = 1'b0;
      bus.id_long     = 1'b0;
      bus.id_long_lat = '0;
      bus.stg_rd      = '0;
      bus.stg_we      = '0;
      bus.stg_rdy     = '0;
      bus.ex_cc_we    = 1'b0;
   endtask

   task automatic set_src(input int i, input int r, input logic use_i);
      bus.id_src_reg[i*REGW +: REGW] = REGW'(r);
      bus.id_src_use[i]              = use_i;
   endtask

   task automatic set_stg(input int k, input int r, input logic we, input logic rdy);
      bus.stg_rd[k*REGW +: REGW] = REGW'(r);
      bus.stg_we[k]              = we;
      bus.stg_rdy[k]             = rdy;
   endtask

   task automatic long_op(input int rd, input int lat);
      bus.id_valid    = 1'b1;
      bus.id_long     = 1'b1;
      bus.id_we       = 1'b1;
      bus.id_rd       = REGW'(rd);
      bus.id_long_lat = CNTW'(lat);
   endtask

   // Queue the expected response for the current inputs and advance one cycle.
   task automatic vec(input string nm, input logic [FW-1:0] fwd, input logic stall,
                      input logic lb, input logic chk_sc, input int sc);
      exp_t x;
      x.nm     = nm;
      x.fwd    = fwd;
      x.stall  = stall;
      x.lb     = lb;
      x.chk_sc = chk_sc;
      x.sc     = PCW'(sc);
      exp_q.push_back(x);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   task automatic step_nc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk         = 1'b0;
      rst         = 1'b1;
      chk_en      = 1'b0;
      applied     = 0;
      miscompares = 0;
      clr();
      @(posedge clk);
      #1;

      // Reset forces outputs low even with a live load-use hazard.
      bus.id_valid = 1'b1;
      set_src(0, 5, 1'b1);
      set_stg(0, 5, 1'b1, 1'b0);
      vec("reset_hold", 6'b000000, 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;

      clr(); bus.id_valid = 1'b1;
      set_src(0, 5, 1'b1); set_stg(0, 5, 1'b1, 1'b1); set_stg(2, 5, 1'b1, 1'b1);
      vec("fwd_young", 6'b000001, 1'b0, 1'b0, 1'b1, 0);
      set_stg(0, 5, 1'b0, 1'b1);
      vec("fwd_old", 6'b000011, 1'b0, 1'b0, 1'b1, 0);

      clr(); bus.id_valid = 1'b1;
      set_stg(0, 7, 1'b1, 1'b0); set_src(1, 7, 1'b1);
      vec("load_use", 6'b000100, 1'b1, 1'b0, 1'b1, 0);
      clr(); bus.id_valid = 1'b1;
      set_stg(1, 7, 1'b1, 1'b1); set_src(1, 7, 1'b1);
      vec("load_use_release", 6'b001000, 1'b0, 1'b0, 1'b1, 1);
      set_stg(0, 7, 1'b1, 1'b0);
      vec("young_not_ready", 6'b000100, 1'b1, 1'b0, 1'b1, 1);

      clr(); rst = 1'b1;
      vec("reset_pulse", 6'b000000, 1'b0, 1'b0, 1'b1, 2);
      rst = 1'b0;

      clr(); long_op(3, 4);
      vec("long_issue", 6'b000000, 1'b0, 1'b0, 1'b1, 0);
      clr(); bus.id_valid = 1'b1; set_src(0, 3, 1'b1);
      for (int c = 0; c < 4; c++)
         vec("long_wait", 6'b000000, 1'b1, 1'b1, 1'b1, c);
      vec("long_release", 6'b000000, 1'b0, 1'b0, 1'b1, 4);

      clr(); long_op(3, 2);
      vec("long2_issue", 6'b000000, 1'b0, 1'b0, 1'b1, 4);
      clr(); long_op(4, 1);
      vec("structural", 6'b000000, 1'b1, 1'b1, 1'b1, 4);
      clr(); bus.id_valid = 1'b1; bus.id_we = 1'b1; bus.id_rd = 5'd3;
      vec("waw", 6'b000000, 1'b1, 1'b1, 1'b1, 5);
      vec("waw_release", 6'b000000, 1'b0, 1'b0, 1'b1, 6);

      clr(); long_op(9, 0);
      vec("lat0_issue", 6'b000000, 1'b0, 1'b0, 1'b1, 6);
      clr(); bus.id_valid = 1'b1; set_src(2, 9, 1'b1);
      vec("lat0_busy", 6'b000000, 1'b1, 1'b1, 1'b1, 6);
      vec("lat0_clean", 6'b000000, 1'b0, 1'b0, 1'b1, 7);

      clr(); bus.id_valid = 1'b1; set_src(0, 0, 1'b1); set_stg(0, 0, 1'b1, 1'b0);
      vec("r0_source", 6'b000000, 1'b0, 1'b0, 1'b1, 7);

      clr(); bus.id_use_cc = 1'b1; bus.ex_cc_we = 1'b1;
      set_stg(0, 7, 1'b1, 1'b0); set_src(1, 7, 1'b1);
      vec("bubble_no_stall", 6'b000100, 1'b0, 1'b0, 1'b1, 7);
      clr(); bus.id_valid = 1'b1; bus.id_use_cc = 1'b1; bus.ex_cc_we = 1'b1;
      vec("cc_hazard", 6'b000000, 1'b1, 1'b0, 1'b1, 7);

      clr(); long_op(0, 5);
      vec("rd0_long", 6'b000000, 1'b0, 1'b0, 1'b1, 8);
      clr();
      vec("rd0_no_mark", 6'b000000, 1'b0, 1'b0, 1'b1, 8);
      clr(); long_op(6, 3); bus.id_valid = 1'b0;
      vec("bubble_long", 6'b000000, 1'b0, 1'b0, 1'b1, 8);
      clr();
      vec("bubble_no_issue", 6'b000000, 1'b0, 1'b0, 1'b1, 8);

      clr(); long_op(10, 6);
      vec("mid_issue", 6'b000000, 1'b0, 1'b0, 1'b1, 8);
      clr(); bus.id_valid = 1'b1; set_src(0, 10, 1'b1);
      vec("mid_busy", 6'b000000, 1'b1, 1'b1, 1'b1, 8);
      rst = 1'b1;
      vec("mid_reset", 6'b000000, 1'b0, 1'b0, 1'b1, 9);
      rst = 1'b0;
      vec("post_reset", 6'b000000, 1'b0, 1'b0, 1'b1, 0);

      clr(); bus.id_valid = 1'b1; bus.id_use_cc = 1'b1; bus.ex_cc_we = 1'b1;
      for (int c = 0; c < 70; c++)
         step_nc();
      vec("saturate", 6'b000000, 1'b1, 1'b0, 1'b1, 63);
      clr();
      vec("saturate_hold", 6'b000000, 1'b0, 1'b0, 1'b1, 63);

      step_nc();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard and forwarding unit for the ID stage of the pipeline. It generalises operand forwarding to NSRC sources and NSTG producer stages. It also adds a registered scoreboard for a non-pipelined long-latency unit (multiply/divide), plus a saturating stall-cycle counter. It sits beside the register file and drives the PC/IF-ID enables and the ID/EX bubble insert.

## Interface
Parameters:
- NSRC, 3, source operand ports examined in ID (rs1, rs2, rd-as-source).
- NSTG, 3, forwarding producer stages; index 0 is youngest (EX), then MEM, WB.
- REGW, 5, register-number width; register 0 is hardwired zero.
- CNTW, 4, long-op latency counter width.
- PCW, 16, stall performance counter width.
- SELW, derived clog2(NSTG+1), forward-select width per source.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_src_reg  in  NSRC*REGW  source register numbers, source i at [i*REGW +: REGW].
- id_src_use  in  NSRC  source i is actually read.
- id_use_cc  in  1  ID instruction reads condition codes.
- id_rd  in  REGW  ID destination register.
- id_we  in  1  ID instruction writes id_rd.
- id_long  in  1  ID instruction is a long-latency op.
- id_long_lat  in  CNTW  cycles until the long-op result is in the RF.
- stg_rd  in  NSTG*REGW  destination register per stage.
- stg_we  in  NSTG  stage writes the RF and is not a bubble.
- stg_rdy  in  NSTG  stage result is available for forwarding (0 for a load in EX).
- ex_cc_we  in  1  EX instruction writes condition codes.
- fwd_sel  out  NSRC*SELW  per source: 0 = RF, k = stage k-1.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- flush_e  out  1  insert bubble into ID/EX.
- long_busy  out  1  long unit occupied.
- stall_cycles  out  PCW  saturating count of stalled cycles.

## Operation
- Forwarding per source i: a stage matches when id_src_use[i], the register is nonzero, stg_we[k], and stg_rd[k]==reg. The lowest matching k wins, and fwd_sel = k+1; with no match, fwd_sel = 0.
- Not-ready hazard: the winning stage has stg_rdy[k]=0. A match on an older stage does not mask a not-ready younger match.
- CC hazard: id_use_cc && ex_cc_we.
- Scoreboard: per-register busy counter cnt[r] (CNTW bits) for r=1..2^REGW-1.
  - A source is busy when id_src_use[i] and cnt[reg]!=0.
  - WAW: id_we with cnt[id_rd]!=0 is also a hazard.
- Structural hazard: id_long && long_busy. long_busy is 1 when any counter is nonzero.
- stall = id_valid && (not-ready || cc || scoreboard || WAW || structural). While stalled: stall_f = stall_d = flush_e = stall.
- Issue: id_valid && !stall && id_long && id_we && id_rd!=0 loads cnt[id_rd] = max(id_long_lat, 1). id_rd = 0 never marks.
- Every nonzero counter decrements by 1 each cycle. A counter at 1 clears, so its register reads clean from the RF the next cycle.
- An issue and a decrement of the same register in the same cycle cannot occur, because WAW stalls the issue.
- stall_cycles increments on each cycle with stall=1 and holds at all-ones.

## Timing
- fwd_sel, stall_f, stall_d, flush_e and long_busy are combinational from the inputs and registered state. There is no added latency.
- The scoreboard and stall_cycles update at posedge clk.
- Reset (synchronous, active-high): on the first posedge with rst=1, all cnt = 0 and stall_cycles = 0.
  - While rst=1, every combinational output is forced to 0, including fwd_sel = 0.
  - Reset mid long-op discards the pending counter.
- Bubbles (id_valid=0) never stall and never issue, but counters keep decrementing.
- A long op issued at cycle t with latency L makes its destination register busy during cycles t+1..t+L and clean at t+L+1.

## Structure
- Shared package:
  - SELW derivation function.
  - FWD_RF = 0 constant.
  - Default REGW and NSRC.
  - Register-zero constant.
- One sub-module, sb_counter: a single CNTW-bit countdown with load and busy output, instantiated 2^REGW-1 times through a generate loop.
- All remaining logic lives in the top-level module.

## Test plan
- Forward priority: src0=r5 used; stg 0 and 2 both write r5 with rdy=1 -> fwd_sel[0]=1. With stage 0 not writing -> fwd_sel[0]=3.
- Load-use: stg0 rd=r7, we=1, rdy=0; src1=r7 -> stall_f = stall_d = flush_e = 1. Next cycle, with stage 1 holding r7 and rdy=1 -> no stall, fwd_sel[1]=2.
- Long op latency: issue a long op with rd=r3, lat=4 at cycle t; a consumer of r3 -> stalled cycles t+1..t+4, released at t+5. stall_cycles = 4.
- Structural and WAW hazards:
  - A second long op while long_busy -> stall.
  - A non-long write to r3 while cnt[3]!=0 -> stall.
  - lat=0 -> busy for exactly 1 cycle.
- Register zero and bubbles:
  - A source of r0 with a matching stage -> fwd_sel=0, no stall.
  - id_valid=0 with a hazard present -> no stall.
  - A long op with rd=0 -> long_busy stays 0.
- Reset mid-op: assert rst two cycles after issuing a lat=6 long op -> outputs 0, long_busy=0 after the posedge, stall_cycles=0. Also check stall_cycles saturation at 2^PCW-1.
